alu_cmd_decoder: RTL and testbench
==================================

# alu_cmd_decoder

Byte-stream command decoder that sits directly upstream of the ALU stage. It accepts framed commands over an 8-bit valid/ready byte interface, then drives the ALU's A, B, data_enable, control and control_enable inputs with a single-cycle issue pulse. It also detects malformed frames and inter-byte timeouts, and counts issued commands.

## Interface
- TIMEOUT, 255: idle cycles allowed between bytes of one frame before abort (1..255).
- SYNC, 3'b101: required value of header bits [7:5].
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high.
- in_data  input  8  incoming byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  decoder accepts a byte this cycle; transfer = in_valid && in_ready at posedge.
- A  output  8  operand A to ALU (registered).
- B  output  8  operand B to ALU (registered).
- control  output  4  ALU opcode (registered).
- data_enable  output  1  A/B carry fresh operands this issue (registered).
- control_enable  output  1  one-cycle issue strobe (registered).
- frame_error  output  1  one-cycle pulse on a bad header or a timeout.
- cmd_count  output  8  number of issued commands, mod 256.

## Operation
- Header byte: [7:5] = SYNC, [4] = D (operands follow), [3:0] = opcode.
- D=1 frames: header, A byte, B byte. D=0 frames: header only; the ALU reuses its stored operands.
- States:
  - IDLE: waits for a header.
    - Header [7:5] != SYNC: pulse frame_error, stay in IDLE, drop the byte.
    - Valid header, D=1: latch opcode and D, go to GET_A.
    - Valid header, D=0: latch opcode and D, go to ISSUE.
  - GET_A: on transfer, latch the byte into the A shadow register, go to GET_B.
  - GET_B: on transfer, latch the byte into the B shadow register, go to ISSUE.
  - ISSUE: lasts exactly one cycle, then returns to IDLE.
    - On entry, load outputs: control = opcode, control_enable = 1, data_enable = D.
    - A/B outputs load from the shadow registers only when D=1; otherwise they keep their previous values.
- in_ready = 1 in IDLE, GET_A and GET_B. in_ready = 0 in ISSUE and while reset is high (combinational from state and reset).
- A, B and control change only when ISSUE is entered and are held stable between issues. Partial frames never disturb them.
- Timeout counter (8-bit):
  - Clears on every transfer and on entry to GET_A.
  - Increments each cycle in GET_A/GET_B without a transfer.
  - Reaching TIMEOUT: pulse frame_error, discard the partial frame, go to IDLE, clear the counter.
  - A transfer in the same cycle the count reaches TIMEOUT wins: the byte is accepted and there is no error.
- cmd_count increments once per ISSUE cycle and wraps 255 -> 0.
- Operand values are not checked (e.g. B=0 with a divide opcode); they pass through unchanged.

## Timing
- Reset (sync): state = IDLE. A, B, control, data_enable, control_enable, frame_error, cmd_count and the timeout counter all = 0.
- Reset mid-frame discards the partial frame. No issue or error pulse is generated.
- D=0 header accepted at edge N: control_enable = 1 during the cycle after edge N, for exactly one cycle.
- D=1 with back-to-back bytes at edges N, N+1, N+2: control_enable = 1 and data_enable = 1 during the cycle after edge N+2.
- Latency: 1 cycle from the last byte to the issue strobe.
- Throughput: one byte per cycle except during the ISSUE cycle (in_ready = 0). Maximum D=1 rate is 1 command per 4 cycles.
- Gaps (in_valid = 0) between bytes are tolerated up to TIMEOUT-1 idle cycles.
- frame_error is registered: it is high during the cycle after the offending edge, for one cycle.
- data_enable is never 1 without control_enable.

## Test plan
- Reset, then bytes 0xB2, 0x07, 0x05 on consecutive cycles -> one cycle later control=2, A=7, B=5, data_enable=1, control_enable=1; next cycle both enables = 0; cmd_count=1.
- After the previous case, send header 0xA0 -> control=0, data_enable=0, control_enable=1, A=7 and B=5 held; cmd_count=2.
- Header 0x52 (bad sync) -> frame_error pulses 1 cycle, no issue, state remains IDLE; a following 0xA3 issues control=3.
- With TIMEOUT=4: send 0xB1, 0x09, then hold in_valid=0 -> frame_error after 4 idle cycles, A/B outputs unchanged. A later valid 3-byte frame issues correctly.
- Hold in_valid=1 with a continuous stream of 0xA0 headers -> in_ready drops every other cycle, one issue per 2 cycles; after 256 issues cmd_count wraps to 0.
- Assert reset while in GET_B -> all outputs 0 on the next cycle, no control_enable. A subsequent frame decodes normally.

Source files
------------

// File: rtl/alu_cmd_decoder.sv
// Framed byte-stream command decoder feeding the ALU stage: parses header/operand
// frames, issues a one-cycle control strobe, flags bad headers and inter-byte timeouts.
module alu_cmd_decoder #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [2:0]  SYNC    = 3'b101
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [3:0] control,
  output logic       data_enable,
  output logic       control_enable,
  output logic       frame_error,
  output logic [7:0] cmd_count
);

  typedef enum logic [1:0] {IDLE, GET_A, GET_B, ISSUE} state_t;

  // The idle cycle that would bring the gap count up to TIMEOUT aborts the frame.
  localparam logic [7:0] LAST_IDLE = 8'(TIMEOUT - 1);

  state_t     state;
  logic [3:0] opcode;
  logic [7:0] a_shadow;
  logic [7:0] idle_count;
  logic       transfer;

  assign in_ready = (state != ISSUE) && !reset;
  assign transfer = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      opcode         <= 4'd0;
      a_shadow       <= 8'd0;
      idle_count     <= 8'd0;
      A              <= 8'd0;
      B              <= 8'd0;
      control        <= 4'd0;
      data_enable    <= 1'b0;
      control_enable <= 1'b0;
      frame_error    <= 1'b0;
      cmd_count      <= 8'd0;
    end else begin
      control_enable <= 1'b0;
      data_enable    <= 1'b0;
      frame_error    <= 1'b0;
      case (state)
        IDLE: begin
          if (transfer) begin
            if (in_data[7:5] != SYNC) begin
              frame_error <= 1'b1;
            end else if (in_data[4]) begin
              opcode     <= in_data[3:0];
              idle_count <= 8'd0;
              state      <= GET_A;
            end else begin
              // Header-only command: the ALU keeps its previous operands.
              control        <= in_data[3:0];
              control_enable <= 1'b1;
              cmd_count      <= cmd_count + 8'd1;
              state          <= ISSUE;
            end
          end
        end
        GET_A: begin
          if (transfer) begin
            a_shadow   <= in_data;
            idle_count <= 8'd0;
            state      <= GET_B;
          end else if (idle_count == LAST_IDLE) begin
            frame_error <= 1'b1;
            idle_count  <= 8'd0;
            state       <= IDLE;
          end else begin
            idle_count <= idle_count + 8'd1;
          end
        end
        GET_B: begin
          if (transfer) begin
            // B goes straight from the bus so operands land together with the strobe.
            A              <= a_shadow;
            B              <= in_data;
            control        <= opcode;
            data_enable    <= 1'b1;
            control_enable <= 1'b1;
            cmd_count      <= cmd_count + 8'd1;
            idle_count     <= 8'd0;
            state          <= ISSUE;
          end else if (idle_count == LAST_IDLE) begin
            frame_error <= 1'b1;
            idle_count  <= 8'd0;
            state       <= IDLE;
          end else begin
            idle_count <= idle_count + 8'd1;
          end
        end
        ISSUE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_decoder.sv
// Randomised bench for alu_cmd_decoder against a frame-level reference model
// (byte queue per frame, gap counter), with the directed cases run first.
module tb_alu_cmd_decoder;

  localparam int unsigned TO = 4;

  logic       clock;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] control;
  logic       data_enable;
  logic       control_enable;
  logic       frame_error;
  logic [7:0] cmd_count;

  alu_cmd_decoder #(.TIMEOUT(TO), .SYNC(3'b101)) dut (
    .clock(clock),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(A),
    .B(B),
    .control(control),
    .data_enable(data_enable),
    .control_enable(control_enable),
    .frame_error(frame_error),
    .cmd_count(cmd_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int errors = 0;
  int checks = 0;
  int issues = 0;

  // Reference model state
  logic [7:0] frame[$];
  int         gap = 0;
  bit         busy = 0;
  logic [7:0] exp_a = 0, exp_b = 0, exp_count = 0;
  logic [3:0] exp_ctrl = 0;
  logic       exp_ce = 0, exp_de = 0, exp_fe = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_issue(input logic [3:0] op, input bit with_data,
                             input logic [7:0] a, input logic [7:0] b);
    exp_ce = 1;
    exp_de = with_data;
    exp_ctrl = op;
    if (with_data) begin
      exp_a = a;
      exp_b = b;
    end
    exp_count = exp_count + 8'd1;
    busy = 1;
    issues++;
    $display("issue %0d: op=%h data=%0d A=%h B=%h count=%0d", issues, op, with_data,
             exp_a, exp_b, exp_count);
  endtask

  // Predicts what the next rising edge does, given the inputs in front of it.
  task automatic model_step(input logic v, input logic [7:0] d, input logic r);
    logic [7:0] hdr;
    exp_ce = 0;
    exp_de = 0;
    exp_fe = 0;
    if (r) begin
      frame.delete();
      gap = 0;
      busy = 0;
      exp_a = 0;
      exp_b = 0;
      exp_ctrl = 0;
      exp_count = 0;
    end else if (busy) begin
      busy = 0;
    end else if (frame.size() == 0) begin
      if (v) begin
        if (d[7:5] != 3'b101) exp_fe = 1;
        else if (d[4]) begin
          frame.push_back(d);
          gap = 0;
        end else model_issue(d[3:0], 0, 8'd0, 8'd0);
      end
    end else if (v) begin
      frame.push_back(d);
      gap = 0;
      if (frame.size() == 3) begin
        hdr = frame[0];
        model_issue(hdr[3:0], 1, frame[1], frame[2]);
        frame.delete();
      end
    end else begin
      gap++;
      if (gap == int'(TO)) begin
        exp_fe = 1;
        frame.delete();
        gap = 0;
      end
    end
  endtask

  // One clock cycle: drive, check readiness, advance model, then compare outputs.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    in_valid = v;
    in_data = d;
    reset = r;
    #1;
    check("in_ready", in_ready, !r && !busy);
    model_step(v, d, r);
    @(posedge clock);
    @(negedge clock);
    check("control_enable", control_enable, exp_ce);
    check("data_enable", data_enable, exp_de);
    check("frame_error", frame_error, exp_fe);
    check("control", control, exp_ctrl);
    check("A", A, exp_a);
    check("B", B, exp_b);
    check("cmd_count", cmd_count, exp_count);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    in_valid = 0;
    in_data = 0;
    reset = 1;
    cycle(0, 8'h00, 1);
    cycle(1, 8'hA5, 1);

    // Full operand frame, then header-only reuse
    cycle(1, 8'hB2, 0); cycle(1, 8'h07, 0); cycle(1, 8'h05, 0);
    idle(2);
    cycle(1, 8'hA0, 0);
    idle(2);
    // Bad sync then a good header
    cycle(1, 8'h52, 0); cycle(1, 8'hA3, 0);
    idle(2);
    // Timeout in GET_B, then a clean frame
    cycle(1, 8'hB1, 0); cycle(1, 8'h09, 0);
    idle(6);
    cycle(1, 8'hB4, 0); cycle(1, 8'h11, 0); cycle(1, 8'h22, 0);
    idle(1);
    // Gap of TIMEOUT-1 is tolerated, timeout in GET_A
    cycle(1, 8'hB6, 0); idle(TO - 1); cycle(1, 8'h44, 0); idle(TO - 1); cycle(1, 8'h55, 0);
    idle(1);
    cycle(1, 8'hB7, 0); idle(TO + 1);
    // Continuous header stream: 256 issues wraps the count
    for (int i = 0; i < 512; i++) cycle(1, 8'hA0, 0);
    idle(1);
    // Reset while waiting for B, then a normal frame
    cycle(1, 8'hB5, 0); cycle(1, 8'h33, 0); cycle(0, 8'h00, 1);
    cycle(1, 8'hB9, 0); cycle(1, 8'h66, 0); cycle(1, 8'h77, 0);
    idle(1);

    // Random traffic: mostly good headers, random gaps, occasional reset
    for (int i = 0; i < 2500; i++) begin
      logic [7:0] d;
      logic v;
      logic r;
      d = 8'($urandom);
      if ($urandom_range(0, 9) < 8) d[7:5] = 3'b101;
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 199) == 0);
      cycle(v, d, r);
      if ($urandom_range(0, 29) == 0) idle($urandom_range(1, TO + 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
